uart_cmd_sched: RTL
===================

Name: uart_cmd_sched

Overview:
- Shares one UART command port among NUM_REQ requesters. Each requester sends a 16-bit command; the MSB is the read/write flag (1 = read).
- Round-robin arbitration. One command is in flight at a time.
- Watches the UART busy/done handshake and waits for the read response on read commands.
- Routes an ack or read data back to the requester that issued the command.
- Sits between register-access masters and the UART core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CMD_WIDTH, 16, command width; bit CMD_WIDTH-1 is the R/W flag
- READ_WIDTH, 8, read data width
- TIMEOUT_CYC, 200000, watchdog limit in clk cycles (used only with the macro)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- req_vld  in  NUM_REQ  per-requester command valid
- req_cmd  in  NUM_REQ*CMD_WIDTH  packed commands; requester i occupies [i*CMD_WIDTH +: CMD_WIDTH]
- req_rdy  out  NUM_REQ  one-hot, 1-cycle accept pulse
- rsp_vld  out  NUM_REQ  one-hot, 1-cycle completion pulse
- rsp_data  out  READ_WIDTH  read data; valid while rsp_vld is nonzero
- rsp_err  out  1  timeout flag; valid with rsp_vld
- uart_cmd  out  CMD_WIDTH  command to UART
- uart_cmd_vld  out  1  command valid to UART
- uart_cmd_rdy  in  1  UART idle/ready; drops while busy
- uart_read_rdy  in  1  UART read-data strobe
- uart_read_data  in  READ_WIDTH  UART read data

Behaviour:
- Reset values: all outputs 0. The round-robin pointer resets to 0, state to IDLE, and all internal buffers clear.
- Round-robin search starts at ptr and wraps modulo NUM_REQ. After a grant to requester g, ptr = (g+1) mod NUM_REQ.
- State machine: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, WAIT_RSP, RESP.
- IDLE:
  - If any req_vld is set, grant the winner g.
  - Latch req_cmd[g] into cmd_buf, latch g, pulse req_rdy[g] for one cycle, go to ISSUE.
  - No req_vld: stay in IDLE.
- ISSUE:
  - uart_cmd_vld = 1 and uart_cmd = cmd_buf, both held stable.
  - Transfer happens when uart_cmd_vld && uart_cmd_rdy are high on a clk edge. Then deassert uart_cmd_vld and go to WAIT_BUSY.
- WAIT_BUSY: wait for uart_cmd_rdy = 0, then go to WAIT_DONE.
- WAIT_DONE: wait for uart_cmd_rdy = 1.
  - Write (cmd_buf MSB = 0): go to RESP.
  - Read: go to WAIT_RSP, or go straight to RESP if the response was already captured.
- Response capture:
  - A uart_read_rdy pulse in WAIT_DONE or WAIT_RSP loads uart_read_data into rsp_buf and sets got_rsp.
  - In WAIT_RSP, capture moves the FSM to RESP on the next cycle.
  - uart_read_rdy in any other state is ignored.
- RESP:
  - rsp_vld[g] = 1 for exactly one cycle.
  - rsp_data = rsp_buf for reads, 0 for writes.
  - Clear got_rsp, go to IDLE.
- Minimum write latency, from the req_rdy pulse to the rsp_vld pulse, is ISSUE + WAIT_BUSY + WAIT_DONE + RESP = 4 cycles plus UART busy time.
- Simultaneous requests: exactly one grant per IDLE visit. Requesters that lose keep req_vld high and hold req_cmd stable until their req_rdy pulse.
- A requester may raise req_vld again in the cycle of its own rsp_vld. That request is arbitrated on the next IDLE cycle, after every other pending requester that is ahead of it in pointer order.
- Reset mid-operation aborts the transaction immediately. No response is produced and all state clears.

Optional Feature:
- Macro: UART_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_BUSY and runs through WAIT_BUSY, WAIT_DONE and WAIT_RSP.
  - When it reaches TIMEOUT_CYC-1, the FSM goes to RESP with rsp_err = 1 and rsp_data = 0.
  - The counter is $clog2(TIMEOUT_CYC) bits wide and saturates (no wrap).
- Undefined:
  - No counter is built and rsp_err is tied to 0.
  - The FSM waits indefinitely.

Decomposition:
- Package uart_sched_pkg holds:
  - the state enum (3-bit encoding);
  - the RW_BIT = CMD_WIDTH-1 constant;
  - default widths (CMD_WIDTH 16, READ_WIDTH 8);
  - the function that extracts the requester slice.
- One sub-module, uart_rr_arb:
  - combinational one-hot grant from req_vld and ptr;
  - registered pointer update on the grant enable.

Test Plan:
- Single write: req_vld[0] with cmd 16'h1234; UART model drops rdy for 20 cycles -> req_rdy[0] pulses once, uart_cmd = 16'h1234, then rsp_vld = 4'b0001 with rsp_data = 0, rsp_err = 0.
- Read: req_vld[2] with cmd 16'h8A00; model returns read_data = 8'h5C after rdy rises -> rsp_vld = 4'b0100 with rsp_data = 8'h5C.
- Early response: the model pulses uart_read_rdy with 8'hA7 while still busy (WAIT_DONE) -> data is kept, and rsp_vld fires exactly once after rdy rises.
- Fairness: all 4 requesters hold req_vld for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no requester is granted twice before the others.
- Timeout (macro on, TIMEOUT_CYC = 50): read with no uart_read_rdy -> rsp_vld pulses with rsp_err = 1, rsp_data = 0, about 50 cycles after WAIT_BUSY entry; the next request then proceeds normally.
- Reset during WAIT_DONE: all outputs read 0 the next cycle, no rsp_vld is produced, and a new request after reset is granted to requester 0 first.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding, widths and slice helper for the UART command scheduler.
package uart_sched_pkg;
  localparam int DEF_CMD_WIDTH  = 16;
  localparam int DEF_READ_WIDTH = 8;
  localparam int RW_BIT         = DEF_CMD_WIDTH - 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, WAIT_RSP, RESP} state_e;
  function automatic int req_lsb(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: one-hot round-robin grant starting at ptr; ptr moves past the winner when en_i is high.
module uart_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] ptr_q, ptr_d, j;
  // Scan from the farthest slot back so the one nearest ptr wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_q) + k) % N);
      if (req_i[j]) idx_o = j;
    end
    gnt_o[idx_o] = |req_i;
    ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else if (en_i && |req_i) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: shares one UART command port among NUM_REQ requesters, one command in flight.
// Optional watchdog built when UART_SCHED_TIMEOUT_EN is defined.
module uart_cmd_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CMD_WIDTH   = DEF_CMD_WIDTH,
  parameter int READ_WIDTH  = DEF_READ_WIDTH,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_vld,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  output logic [NUM_REQ-1:0]           req_rdy,
  output logic [NUM_REQ-1:0]           rsp_vld,
  output logic [READ_WIDTH-1:0]        rsp_data,
  output logic                         rsp_err,
  output logic [CMD_WIDTH-1:0]         uart_cmd,
  output logic                         uart_cmd_vld,
  input  logic                         uart_cmd_rdy,
  input  logic                         uart_read_rdy,
  input  logic [READ_WIDTH-1:0]        uart_read_data
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int RW = (CMD_WIDTH == DEF_CMD_WIDTH) ? RW_BIT : CMD_WIDTH - 1;
  state_e                state_q;
  logic [CMD_WIDTH-1:0]  cmd_buf_q, gnt_cmd;
  logic [GW-1:0]         g_q, gnt_idx;
  logic [NUM_REQ-1:0]    gnt, req_rdy_q, rsp_vld_q;
  logic [READ_WIDTH-1:0] rsp_buf_q, rsp_data_q, resp_data;
  logic                  got_rsp_q, rsp_err_q, uart_cmd_vld_q;
  logic                  in_wait, capture, is_rd, to_hit, go_resp;
  uart_rr_arb #(.N(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_vld),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );
  always_comb begin
    gnt_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_cmd = req_cmd[req_lsb(i, CMD_WIDTH) +: CMD_WIDTH];
  end
  assign in_wait   = state_q inside {WAIT_BUSY, WAIT_DONE, WAIT_RSP};
  assign capture   = uart_read_rdy && (state_q == WAIT_DONE || state_q == WAIT_RSP);
  assign is_rd     = cmd_buf_q[RW];
  // A read finishing in WAIT_DONE may have its data arrive earlier or in this very cycle.
  assign go_resp   = to_hit
                   || (state_q == WAIT_DONE && uart_cmd_rdy && (!is_rd || got_rsp_q || uart_read_rdy))
                   || (state_q == WAIT_RSP && uart_read_rdy);
  assign resp_data = (to_hit || !is_rd) ? '0 : (capture ? uart_read_data : rsp_buf_q);
`ifdef UART_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (state_q == ISSUE) cnt_q <= '0;
    else if (in_wait && cnt_q != '1) cnt_q <= cnt_q + CW'(1);
  end
  assign to_hit = in_wait && cnt_q == CW'(TIMEOUT_CYC - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign to_hit         = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_buf_q      <= '0;
      g_q            <= '0;
      rsp_buf_q      <= '0;
      got_rsp_q      <= 1'b0;
      req_rdy_q      <= '0;
      rsp_vld_q      <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      uart_cmd_vld_q <= 1'b0;
    end else begin
      req_rdy_q  <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      if (capture) begin
        rsp_buf_q <= uart_read_data;
        got_rsp_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (|req_vld) begin
          cmd_buf_q      <= gnt_cmd;
          g_q            <= gnt_idx;
          req_rdy_q      <= gnt;
          uart_cmd_vld_q <= 1'b1;
          state_q        <= ISSUE;
        end
        ISSUE: if (uart_cmd_rdy) begin
          uart_cmd_vld_q <= 1'b0;
          state_q        <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!uart_cmd_rdy) state_q <= WAIT_DONE;
        WAIT_DONE: if (uart_cmd_rdy) state_q <= WAIT_RSP;
        WAIT_RSP:  state_q <= WAIT_RSP;
        RESP: begin
          got_rsp_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (go_resp) begin
        state_q    <= RESP;
        rsp_vld_q  <= NUM_REQ'(1) << g_q;
        rsp_data_q <= resp_data;
        rsp_err_q  <= to_hit;
      end
    end
  end
  assign req_rdy      = req_rdy_q;
  assign rsp_vld      = rsp_vld_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign uart_cmd     = cmd_buf_q;
  assign uart_cmd_vld = uart_cmd_vld_q;
endmodule
